bomb_game_ctrl: RTL and testbench

- Top-level round sequencer for the bomb dismantlement game.
- Latches a password and hands it to the password-display stage for its show phase. Afterwards it runs a timed input phase in which the player enters the password on switches and presses confirm.
- Declares WIN or LOSE based on match, remaining tries and remaining time.
- Sits between the password source, the show stage, the player switch/button inputs and the status LEDs/displays.

---
 rtl/bomb_game_pkg.sv | 20 ++
 rtl/sec_tick_gen.sv | 32 +++
 rtl/bomb_game_ctrl.sv | 132 +++++++++++++
 tb/tb_bomb_game_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomb_game_pkg.sv
// bomb_game_pkg: shared constants for the bomb dismantlement game controller.
// Holds the FSM state codes, the default password width, the wrong-guess
// time penalty and the default timing/try parameters.
package bomb_game_pkg;

  localparam int PSW_W          = 7;
  localparam int PENALTY_SECS   = 5;
  localparam int DEF_TICK_DIV   = 1000;
  localparam int DEF_INPUT_SECS = 30;
  localparam int DEF_MAX_TRIES  = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHOW  = 3'd2;
  localparam logic [2:0] ST_INPUT = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_WIN   = 3'd5;
  localparam logic [2:0] ST_LOSE  = 3'd6;

endpackage

// File: rtl/sec_tick_gen.sv
// sec_tick_gen: divides clk by TICK_DIV and emits a one-cycle tick on the
// last count. clr restarts the count from zero; hold freezes it in place so
// a paused phase can resume exactly where it left off.
module sec_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running divider counter with clear priority over hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = !hold && !clr && (cnt == LAST);

endmodule

// File: rtl/bomb_game_ctrl.sv
// bomb_game_ctrl: round sequencer for the bomb dismantlement game.
// Latches a password, lets the show stage display it, then runs a timed
// input phase where the player submits guesses until WIN or LOSE.
// Optional feature macro BOMB_PENALTY_EN: a wrong guess also costs
// PENALTY_SECS seconds of remaining time (saturating, LOSE at zero).
module bomb_game_ctrl #(
  parameter int PSW_W      = bomb_game_pkg::PSW_W,
  parameter int TICK_DIV   = bomb_game_pkg::DEF_TICK_DIV,
  parameter int INPUT_SECS = bomb_game_pkg::DEF_INPUT_SECS,
  parameter int MAX_TRIES  = bomb_game_pkg::DEF_MAX_TRIES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PSW_W-1:0] psw_in,
  input  logic [PSW_W-1:0] sw,
  input  logic             confirm,
  input  logic             end_of_show,
  output logic             show_clr,
  output logic             showing,
  output logic [PSW_W-1:0] psw_out,
  output logic [2:0]       state,
  output logic [5:0]       time_left,
  output logic [1:0]       tries_left,
  output logic             win,
  output logic             lose
);

  import bomb_game_pkg::*;

  logic [2:0]       state_nx;
  logic [5:0]       time_nx;
  logic [1:0]       tries_nx;
  logic [PSW_W-1:0] psw_nx;
  logic [PSW_W-1:0] guess;
  logic [PSW_W-1:0] guess_nx;
  logic             tick;
  logic             tick_clr;
  logic             tick_hold;

  // The divider only runs in INPUT; CHECK freezes it, every other state restarts it
  always_comb begin
    tick_clr  = (state != ST_INPUT) && (state != ST_CHECK);
    tick_hold = (state != ST_INPUT);
  end

  sec_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_sec_tick (
    .clk (clk),
    .rst (rst),
    .clr (tick_clr),
    .hold(tick_hold),
    .tick(tick)
  );

  // Next-state and datapath decisions for the round sequencer
  always_comb begin
    state_nx = state;
    time_nx  = time_left;
    tries_nx = tries_left;
    psw_nx   = psw_out;
    guess_nx = guess;
    case (state)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        psw_nx   = psw_in;
        time_nx  = 6'(INPUT_SECS);
        tries_nx = 2'(MAX_TRIES);
        state_nx = ST_SHOW;
      end
      ST_SHOW: begin
        if (end_of_show) state_nx = ST_INPUT;
      end
      ST_INPUT: begin
        if (tick && (time_left <= 6'd1)) begin
          time_nx  = '0;
          state_nx = ST_LOSE;
        end else begin
          if (tick) time_nx = time_left - 6'd1;
          if (confirm) begin
            guess_nx = sw;
            state_nx = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (guess == psw_out) begin
          state_nx = ST_WIN;
        end else begin
          tries_nx = tries_left - 2'd1;
`ifdef BOMB_PENALTY_EN
          time_nx  = (time_left > 6'(PENALTY_SECS)) ? time_left - 6'(PENALTY_SECS) : 6'd0;
          state_nx = ((tries_nx == 2'd0) || (time_nx == 6'd0)) ? ST_LOSE : ST_INPUT;
`else
          state_nx = (tries_nx == 2'd0) ? ST_LOSE : ST_INPUT;
`endif
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Register state, datapath and the outputs decoded from the upcoming state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      show_clr   <= 1'b1;
      showing    <= 1'b0;
      psw_out    <= '0;
      time_left  <= '0;
      tries_left <= '0;
      win        <= 1'b0;
      lose       <= 1'b0;
      guess      <= '0;
    end else begin
      state      <= state_nx;
      time_left  <= time_nx;
      tries_left <= tries_nx;
      psw_out    <= psw_nx;
      guess      <= guess_nx;
      show_clr   <= (state_nx == ST_IDLE) || (state_nx == ST_LOAD) ||
                    (state_nx == ST_WIN)  || (state_nx == ST_LOSE);
      showing    <= (state_nx == ST_SHOW);
      win        <= (state_nx == ST_WIN);
      lose       <= (state_nx == ST_LOSE);
    end
  end

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// tb_bomb_game_ctrl: randomized scoreboard bench for bomb_game_ctrl.
// A round-level reference model predicts every round outcome and retry;
// a monitor compares each one as the DUT presents it.
module tb_bomb_game_ctrl;

  localparam int PSW_W      = 7;
  localparam int TICK_DIV   = 4;
  localparam int INPUT_SECS = 12;
  localparam int MAX_TRIES  = 3;
  localparam int PEN_SECS   = 5;

  localparam int C_INPUT = 3;
  localparam int C_WIN   = 5;
  localparam int C_LOSE  = 6;

  localparam int M_RANDOM      = 0;
  localparam int M_HAPPY       = 1;
  localparam int M_WRONG_RIGHT = 2;
  localparam int M_EXHAUST     = 3;
  localparam int M_TIMEOUT     = 4;
  localparam int M_LASTTICK    = 5;
  localparam int M_PENALTY     = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             confirm = 1'b0;
  logic             end_of_show = 1'b0;
  logic [PSW_W-1:0] psw_in = '0;
  logic [PSW_W-1:0] sw = '0;
  logic             show_clr;
  logic             showing;
  logic [PSW_W-1:0] psw_out;
  logic [2:0]       state;
  logic [5:0]       time_left;
  logic [1:0]       tries_left;
  logic             win;
  logic             lose;

  always #5 clk = ~clk;

  bomb_game_ctrl #(
    .PSW_W(PSW_W),
    .TICK_DIV(TICK_DIV),
    .INPUT_SECS(INPUT_SECS),
    .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .psw_in(psw_in),
    .sw(sw),
    .confirm(confirm),
    .end_of_show(end_of_show),
    .show_clr(show_clr),
    .showing(showing),
    .psw_out(psw_out),
    .state(state),
    .time_left(time_left),
    .tries_left(tries_left),
    .win(win),
    .lose(lose)
  );

  typedef enum int {P_IDLE, P_LOAD, P_SHOW, P_INPUT, P_CHECK, P_WIN, P_LOSE} phase_t;

  typedef struct {
    int st;
    int tl;
    int tr;
    int psw;
    int w;
    int l;
    int cyc;
  } ev_t;

  phase_t           m_phase = P_IDLE;
  int               m_time = 0;
  int               m_tries = 0;
  int               m_in_cycles = 0;
  logic [PSW_W-1:0] m_psw = '0;
  logic [PSW_W-1:0] m_guess = '0;

  ev_t exp_q[$];
  ev_t mon_e;
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  logic [2:0] prev_st = 3'd0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic void push_event(input int code);
    ev_t e;
    e.st  = code;
    e.tl  = m_time;
    e.tr  = m_tries;
    e.psw = int'(m_psw);
    e.w   = (code == C_WIN) ? 1 : 0;
    e.l   = (code == C_LOSE) ? 1 : 0;
    e.cyc = cyc + 1;
    exp_q.push_back(e);
  endfunction

  // Game rules applied to the inputs present at the upcoming clock edge
  task automatic model_edge();
    case (m_phase)
      P_IDLE, P_WIN, P_LOSE: begin
        if (start) m_phase = P_LOAD;
      end
      P_LOAD: begin
        m_psw   = psw_in;
        m_time  = INPUT_SECS;
        m_tries = MAX_TRIES;
        m_phase = P_SHOW;
      end
      P_SHOW: begin
        if (end_of_show) begin
          m_phase     = P_INPUT;
          m_in_cycles = 0;
        end
      end
      P_INPUT: begin
        m_in_cycles++;
        if (m_in_cycles % TICK_DIV == 0) begin
          m_time--;
          if (m_time == 0) begin
            m_phase = P_LOSE;
            push_event(C_LOSE);
          end
        end
        if (m_phase == P_INPUT && confirm) begin
          m_guess = sw;
          m_phase = P_CHECK;
        end
      end
      P_CHECK: begin
        if (m_guess == m_psw) begin
          m_phase = P_WIN;
          push_event(C_WIN);
        end else begin
          m_tries--;
`ifdef BOMB_PENALTY_EN
          m_time = (m_time > PEN_SECS) ? m_time - PEN_SECS : 0;
`endif
          if (m_tries == 0 || m_time == 0) begin
            m_phase = P_LOSE;
            push_event(C_LOSE);
          end else begin
            m_phase = P_INPUT;
            push_event(C_INPUT);
          end
        end
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic applyStimulus();
    model_edge();
    step();
  endtask

  task automatic play_round(input int mode);
    int budget;
    int show_len;
    int show_cnt;
    int nconf;
    logic do_conf;
    logic [PSW_W-1:0] guess_val;
    budget   = 0;
    show_cnt = 0;
    nconf    = 0;
    show_len = (mode == M_HAPPY) ? 20 : int'($urandom_range(0, 20));
    start       = 1'b1;
    confirm     = 1'b0;
    end_of_show = 1'b0;
    psw_in      = PSW_W'($urandom);
    applyStimulus();
    while (!(m_phase == P_WIN || m_phase == P_LOSE)) begin
      budget++;
      if (budget > 400) begin
        checkOutput("round_budget", budget, 400);
        break;
      end
      psw_in      = PSW_W'($urandom);
      sw          = PSW_W'($urandom);
      start       = 1'b0;
      confirm     = 1'b0;
      end_of_show = 1'b0;
      case (m_phase)
        P_SHOW: begin
          end_of_show = (show_cnt >= show_len);
          show_cnt++;
          start   = ($urandom_range(0, 3) == 0);
          confirm = ($urandom_range(0, 3) == 0);
        end
        P_INPUT: begin
          start     = ($urandom_range(0, 7) == 0);
          do_conf   = 1'b0;
          guess_val = m_psw ^ PSW_W'($urandom_range(1, 127));
          case (mode)
            M_RANDOM: begin
              do_conf = ($urandom_range(0, 5) == 0);
              if ($urandom_range(0, 2) == 0) guess_val = m_psw;
            end
            M_HAPPY: begin
              do_conf   = 1'b1;
              guess_val = m_psw;
            end
            M_WRONG_RIGHT: begin
              do_conf = 1'b1;
              if (nconf >= 1) guess_val = m_psw;
            end
            M_EXHAUST: do_conf = 1'b1;
            M_LASTTICK: begin
              do_conf   = (m_time == 1) && ((m_in_cycles + 1) % TICK_DIV == 0);
              guess_val = m_psw;
            end
            M_PENALTY: begin
              do_conf = (nconf == 0 && m_time == 10) || (nconf == 1 && m_time == 4);
            end
            default: do_conf = 1'b0;
          endcase
          if (do_conf) begin
            confirm = 1'b1;
            sw      = guess_val;
            nconf++;
          end
        end
        default: begin
          start   = ($urandom_range(0, 3) == 0);
          confirm = ($urandom_range(0, 3) == 0);
        end
      endcase
      applyStimulus();
    end
    start   = 1'b0;
    confirm = 1'b0;
  endtask

  task automatic reset_mid_show();
    start  = 1'b1;
    psw_in = PSW_W'($urandom);
    applyStimulus();
    start = 1'b0;
    applyStimulus();
    repeat (3) applyStimulus();
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_state", int'(state), 0);
    checkOutput("async_rst_showing", int'(showing), 0);
    checkOutput("async_rst_show_clr", int'(show_clr), 1);
    checkOutput("async_rst_win", int'(win), 0);
    checkOutput("async_rst_lose", int'(lose), 0);
    m_phase = P_IDLE;
    m_time  = 0;
    m_tries = 0;
    m_psw   = '0;
    step();
    step();
    rst = 1'b1;
    checkOutput("post_rst_time_left", int'(time_left), 0);
    checkOutput("post_rst_tries_left", int'(tries_left), 0);
    checkOutput("post_rst_psw_out", int'(psw_out), 0);
  endtask

  // Compare each predicted retry/outcome when the DUT presents it
  always @(negedge clk) begin
    if (rst && (state != prev_st) &&
        (state == 3'd5 || state == 3'd6 || (state == 3'd3 && prev_st == 3'd4))) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_event: got state %0d, expected no event", state);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("ev_state", int'(state), mon_e.st);
        checkOutput("ev_cycle", cyc, mon_e.cyc);
        checkOutput("ev_time_left", int'(time_left), mon_e.tl);
        checkOutput("ev_tries_left", int'(tries_left), mon_e.tr);
        checkOutput("ev_psw_out", int'(psw_out), mon_e.psw);
        checkOutput("ev_win", int'(win), mon_e.w);
        checkOutput("ev_lose", int'(lose), mon_e.l);
        checkOutput("ev_showing", int'(showing), 0);
        checkOutput("ev_show_clr", int'(show_clr), (mon_e.w | mon_e.l));
      end
    end
    prev_st = state;
  end

  // Stop a runaway simulation
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, directed rounds, mid-show reset, random rounds
  initial begin
    rst = 1'b0;
    step();
    step();
    checkOutput("rst_state", int'(state), 0);
    checkOutput("rst_show_clr", int'(show_clr), 1);
    checkOutput("rst_showing", int'(showing), 0);
    checkOutput("rst_psw_out", int'(psw_out), 0);
    checkOutput("rst_time_left", int'(time_left), 0);
    checkOutput("rst_tries_left", int'(tries_left), 0);
    checkOutput("rst_win", int'(win), 0);
    checkOutput("rst_lose", int'(lose), 0);
    rst = 1'b1;
    repeat (2) applyStimulus();
    checkOutput("idle_state", int'(state), 0);
    checkOutput("idle_show_clr", int'(show_clr), 1);

    play_round(M_HAPPY);
    play_round(M_WRONG_RIGHT);
    play_round(M_EXHAUST);
    play_round(M_TIMEOUT);
    play_round(M_LASTTICK);
    play_round(M_PENALTY);
    reset_mid_show();
    for (int r = 0; r < 24; r++) begin
      if (r % 3 == 0) play_round(int'($urandom_range(0, 6)));
      else play_round(M_RANDOM);
    end

    repeat (3) applyStimulus();
    checkOutput("final_win", int'(win), (m_phase == P_WIN) ? 1 : 0);
    checkOutput("final_lose", int'(lose), (m_phase == P_LOSE) ? 1 : 0);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
